// File: rtl/seg7_scan.sv
// Digit-scan controller for a multiplexed 7-segment display: steps one digit per scan strobe,
// inserts dead time between digits, and drives active-low anodes/segments from a per-frame snapshot.
module seg7_scan #(
   parameter int NUM_DIGITS   = 4,
   parameter int BLANK_CYCLES = 2,
   parameter bit LZ_SUPPRESS  = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          scan_en,
   input  logic [4*NUM_DIGITS-1:0]       data,
   input  logic [NUM_DIGITS-1:0]         dp,
   input  logic [NUM_DIGITS-1:0]         digit_mask,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [6:0]                    seg,
   output logic                          dp_n,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_start
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t                  state, state_d;
   logic                    scan_en_q;
   logic                    tick;
   logic [CNT_W-1:0]        cnt, cnt_d;
   logic [IDX_W-1:0]        idx_d;
   logic [4*NUM_DIGITS-1:0] snap_data, snap_data_d;
   logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_d;
   logic [NUM_DIGITS-1:0]   snap_mask, snap_mask_d;
   logic [NUM_DIGITS-1:0]   an_d;
   logic [6:0]              seg_d;
   logic                    dp_n_d;
   logic                    frame_start_d;
   logic [NUM_DIGITS-1:0]   blank_vec;
   logic [3:0]              nibble;

   function automatic logic [6:0] hex_decode(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   assign tick   = scan_en & ~scan_en_q;
   assign nibble = snap_data[4*digit_idx +: 4];

   // A digit is blank if masked off, or (with suppression) if it and every digit above it is zero.
   always_comb begin
      logic zero_run;
      zero_run  = 1'b1;
      blank_vec = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run     = zero_run & (snap_data[4*i +: 4] == 4'h0);
         blank_vec[i] = ~snap_mask[i] | (LZ_SUPPRESS && (i > 0) && zero_run);
      end
   end

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      idx_d         = digit_idx;
      an_d          = an;
      seg_d         = seg;
      dp_n_d        = dp_n;
      frame_start_d = 1'b0;
      snap_data_d   = snap_data;
      snap_dp_d     = snap_dp;
      snap_mask_d   = snap_mask;
      unique case (state)
         IDLE, DRIVE: begin
            if (tick) begin
               an_d    = '1;
               seg_d   = 7'h7F;
               dp_n_d  = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = BLANK;
               if (digit_idx == LAST_IDX) begin
                  idx_d         = '0;
                  snap_data_d   = data;
                  snap_dp_d     = dp;
                  snap_mask_d   = digit_mask;
                  frame_start_d = 1'b1;
               end else begin
                  idx_d = digit_idx + 1'b1;
               end
            end
         end
         BLANK: begin
            if (cnt == '0) begin
               state_d = DRIVE;
               if (!blank_vec[digit_idx]) begin
                  an_d   = ~(NUM_DIGITS'(1) << digit_idx);
                  seg_d  = hex_decode(nibble);
                  dp_n_d = ~snap_dp[digit_idx];
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         scan_en_q   <= 1'b0;
         cnt         <= '0;
         digit_idx   <= LAST_IDX;
         an          <= '1;
         seg         <= 7'h7F;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
         snap_data   <= '0;
         snap_dp     <= '0;
         snap_mask   <= '0;
      end else begin
         state       <= state_d;
         scan_en_q   <= scan_en;
         cnt         <= cnt_d;
         digit_idx   <= idx_d;
         an          <= an_d;
         seg         <= seg_d;
         dp_n        <= dp_n_d;
         frame_start <= frame_start_d;
         snap_data   <= snap_data_d;
         snap_dp     <= snap_dp_d;
         snap_mask   <= snap_mask_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: stimulus pushes expected digit frames from a tick-level model,
// a monitor pops them whenever the DUT advances its digit index.
module tb_seg7_scan;

   localparam int N  = 4;
   localparam int B  = 2;
   localparam bit LZ = 1'b1;

   logic           clk;
   logic           rst;
   logic           scan_en;
   logic [4*N-1:0] data;
   logic [N-1:0]   dp;
   logic [N-1:0]   digit_mask;
   logic [N-1:0]   an;
   logic [6:0]     seg;
   logic           dp_n;
   logic [1:0]     digit_idx;
   logic           frame_start;

   seg7_scan #(.NUM_DIGITS(N), .BLANK_CYCLES(B), .LZ_SUPPRESS(LZ)) dut (
      .clk(clk), .rst(rst), .scan_en(scan_en), .data(data), .dp(dp),
      .digit_mask(digit_mask), .an(an), .seg(seg), .dp_n(dp_n),
      .digit_idx(digit_idx), .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           idx;
      logic [N-1:0] an;
      logic [6:0]   seg;
      logic         dp_n;
      logic         fs;
      bit           chk_seg;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model: digit position, last accepted tick time and the frame snapshot.
   int             m_idx    = N - 1;
   int             last_acc = -100;
   logic [4*N-1:0] s_data   = '0;
   logic [N-1:0]   s_dp     = '0;
   logic [N-1:0]   s_mask   = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idx    = N - 1;
      last_acc = -100;
      s_data   = '0;
      s_dp     = '0;
      s_mask   = '0;
   endtask

   // A rising strobe at edge t is taken only once the previous digit's dead time is over.
   task automatic model_tick(input int t);
      exp_t e;
      bit   blank;
      if (t - last_acc <= B) return;
      last_acc = t;
      m_idx    = (m_idx + 1) % N;
      if (m_idx == 0) begin
         s_data = data;
         s_dp   = dp;
         s_mask = digit_mask;
      end
      blank     = !s_mask[m_idx] || (LZ && m_idx > 0 && (s_data >> (4 * m_idx)) == 0);
      e.idx     = m_idx;
      e.fs      = (m_idx == 0);
      e.chk_seg = !blank;
      if (blank) begin
         e.an   = '1;
         e.seg  = 7'h7F;
         e.dp_n = 1'b1;
      end else begin
         e.an   = ~(N'(1) << m_idx);
         e.seg  = seg_lut[s_data[4*m_idx +: 4]];
         e.dp_n = !s_dp[m_idx];
      end
      sb.push_back(e);
   endtask

   // Called on a negedge: the strobe rises for the next posedge.
   task automatic pulse(input int hi, input int lo);
      scan_en = 1'b1;
      model_tick(cyc + 1);
      repeat (hi) @(negedge clk);
      scan_en = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   // Monitor: a change of digit_idx marks an accepted tick.
   initial begin
      int   prev;
      bit   driving;
      exp_t cur;
      prev    = N - 1;
      driving = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev    = N - 1;
            driving = 1'b0;
         end else if (int'(digit_idx) != prev) begin
            prev    = int'(digit_idx);
            driving = 1'b0;
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_advance: digit_idx=%0d, no tick expected", digit_idx);
            end else begin
               cur = sb.pop_front();
               check("tick_idx", digit_idx, cur.idx);
               check("tick_frame_start", frame_start, cur.fs);
               check("tick_an_off", an, {N{1'b1}});
               repeat (B - 1) begin
                  @(negedge clk);
                  check("gap_an_off_fs", {frame_start, an}, {1'b0, {N{1'b1}}});
               end
               @(negedge clk);
               check("drive_an", an, cur.an);
               if (cur.chk_seg) check("drive_seg", seg, cur.seg);
               check("drive_dp_n", dp_n, cur.dp_n);
               check("drive_frame_start", frame_start, 1'b0);
               driving = 1'b1;
            end
         end else if (driving) begin
            check("hold_an_dp", {an, dp_n}, {cur.an, cur.dp_n});
            if (cur.chk_seg) check("hold_seg", seg, cur.seg);
         end
      end
   end

   initial begin
      int w;
      rst        = 1'b0;
      scan_en    = 1'b0;
      data       = 16'h1234;
      dp         = '0;
      digit_mask = '1;
      repeat (3) @(negedge clk);
      check("rst_an", an, {N{1'b1}});
      check("rst_seg", seg, 7'h7F);
      check("rst_dp_n", dp_n, 1'b1);
      check("rst_idx", digit_idx, N - 1);
      check("rst_frame_start", frame_start, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      // Two digits of 1234, then new data mid-frame must wait for the next frame.
      pulse(3, 3);
      pulse(3, 3);
      data = 16'hABCD;
      repeat (6) pulse(2, 3);

      data = 16'h0050;
      repeat (4) pulse(2, 2);
      data = 16'h0000;
      repeat (4) pulse(2, 2);

      data       = 16'h1234;
      digit_mask = 4'b1011;
      dp         = 4'b0001;
      repeat (4) pulse(2, 2);
      digit_mask = '1;
      dp         = '0;

      repeat (60) begin
         if ($urandom_range(0, 2) == 0) begin
            data       = 16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h00FF);
            dp         = N'($urandom);
            digit_mask = N'($urandom_range(0, 3) == 0 ? $urandom : 32'hF);
         end
         pulse($urandom_range(1, 3), $urandom_range(1, 3));
      end

      // Reset in the middle of a driven digit.
      pulse(2, 1);
      repeat (B + 2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      #1;
      check("midrst_an", an, {N{1'b1}});
      check("midrst_seg", seg, 7'h7F);
      check("midrst_dp_n", dp_n, 1'b1);
      check("midrst_idx", digit_idx, N - 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      data = 16'h9876;
      pulse(1, 1);
      pulse(1, 3);
      pulse(2, 2);

      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      repeat (B + 2) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
